// File: rtl/lp_clk_pkg.sv
// ----------------------------------------------------------------------------
// lp_clk_pkg
// Shared definitions for the lp tree serializer phase divider.
//   lp_div_state_e  : divider run state (IDLE / RUN / DRAIN)
//   lp_div_ratio()  : division ratio D = 2^div_log2
//   lp_phase_level(): ideal level of phase k for counter value cnt,
//                     f(cnt)[k] = ((cnt - k) mod d) < d/2, d a power of two
// ----------------------------------------------------------------------------
package lp_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lp_div_state_e;

  localparam int LP_DIV_LOG2_MIN = 1;
  localparam int LP_DIV_LOG2_MAX = 5;

  function automatic int lp_div_ratio(input int div_log2);
    return 1 << div_log2;
  endfunction

  // d is a power of two, so masking with d-1 is the modulo of the wrapped
  // unsigned difference.
  function automatic logic lp_phase_level(input int unsigned cnt,
                                          input int unsigned k,
                                          input int unsigned d);
    return ((cnt - k) & (d - 1)) < (d >> 1);
  endfunction

endpackage

// File: rtl/lp_phase_div_lane.sv
// ----------------------------------------------------------------------------
// lp_phase_div_lane
// One phase lane of the divider: run-mask bit, registered phase output and
// registered per-phase reset.
//   i_clk        : fast clock
//   i_rst        : synchronous active-high reset
//   i_rule_state : state whose mask rules apply at this edge
//   i_rise       : counter reaches this lane's natural rise at this edge
//   i_fall       : ideal level of this lane is low after this edge
//   o_mask_next  : mask value being loaded at this edge (combinational)
//   o_phase      : divided clock for this lane (registered)
//   o_prst       : lane reset, high while the lane is not running (registered)
// ----------------------------------------------------------------------------
module lp_phase_div_lane
  import lp_clk_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  lp_div_state_e i_rule_state,
  input  logic          i_rise,
  input  logic          i_fall,
  output logic          o_mask_next,
  output logic          o_phase,
  output logic          o_prst
);

  logic r_mask;
  logic r_phase;
  logic r_prst;
  logic w_mask_next;

  // A lane only joins at its natural rise and only leaves at its natural
  // fall, so no pulse is ever shortened outside of reset.
  always_comb begin
    w_mask_next = 1'b0;
    case (i_rule_state)
      RUN:     w_mask_next = r_mask | i_rise;
      DRAIN:   w_mask_next = r_mask & ~i_fall;
      default: w_mask_next = 1'b0;
    endcase
  end

  // Output register stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask  <= 1'b0;
      r_phase <= 1'b0;
      r_prst  <= 1'b1;
    end else begin
      r_mask  <= w_mask_next;
      r_phase <= w_mask_next & ~i_fall;
      r_prst  <= ~w_mask_next;
    end
  end

  assign o_mask_next = w_mask_next;
  assign o_phase     = r_phase;
  assign o_prst      = r_prst;

endmodule

// File: rtl/lp_phase_divider.sv
// ----------------------------------------------------------------------------
// lp_phase_divider
// Divides clk_i by D = 2^DIV_LOG2 and produces D registered phases spaced one
// fast cycle apart, each with its own synchronous reset. Start and stop are
// glitch-free: phases join at their natural rise and leave at their natural
// fall.
//   clk_i         : serializer fast clock
//   rst_i         : synchronous active-high reset
//   en_i          : run request (level)
//   resync_i      : one-cycle pulse, drain then restart while en_i is high
//   start_phase_i : counter value loaded when entering RUN
//   phase_o[k]    : divided clock at phase k
//   prst_o[k]     : per-phase reset aligned to phase_o[k]
//   frame_o       : last fast cycle of each divided period, all phases running
//   locked_o      : all phases running
// ----------------------------------------------------------------------------
module lp_phase_divider
  import lp_clk_pkg::*;
#(
  parameter  int DIV_LOG2 = 2,
  localparam int D        = lp_div_ratio(DIV_LOG2)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                resync_i,
  input  logic [DIV_LOG2-1:0] start_phase_i,
  output logic [D-1:0]        phase_o,
  output logic [D-1:0]        prst_o,
  output logic                frame_o,
  output logic                locked_o
);

  lp_div_state_e       r_state;
  lp_div_state_e       w_rule_state;
  lp_div_state_e       w_state_next;
  logic [DIV_LOG2-1:0] r_cnt;
  logic [DIV_LOG2-1:0] w_cnt_adv;
  logic [DIV_LOG2-1:0] w_cnt_next;
  logic [D-1:0]        w_rise;
  logic [D-1:0]        w_fall;
  logic [D-1:0]        w_mask_next;
  logic                w_stop;
  logic                w_drain_empty;
  logic                w_all_run;
  logic                r_frame;
  logic                r_locked;

  // w_rule_state selects which mask rules the lanes apply at this edge. The
  // edge leaving IDLE already uses RUN rules and the edge leaving RUN already
  // uses DRAIN rules. w_cnt_adv is the counter value the lanes evaluate.
  always_comb begin
    w_stop       = ~en_i | resync_i;
    w_cnt_adv    = r_cnt + DIV_LOG2'(1);
    w_rule_state = r_state;
    case (r_state)
      IDLE: begin
        w_cnt_adv    = start_phase_i;
        w_rule_state = en_i ? RUN : IDLE;
      end
      RUN:     w_rule_state = w_stop ? DRAIN : RUN;
      DRAIN:   w_rule_state = DRAIN;
      default: w_rule_state = IDLE;
    endcase
  end

  // Returning to IDLE happens on the edge where the last lane leaves; the
  // counter is reloaded then so an immediate restart begins at start_phase_i.
  always_comb begin
    w_drain_empty = ~|w_mask_next;
    w_all_run     = &w_mask_next;
    w_state_next  = w_rule_state;
    w_cnt_next    = w_cnt_adv;
    if ((w_rule_state == DRAIN) && w_drain_empty) begin
      w_state_next = IDLE;
      w_cnt_next   = start_phase_i;
    end
  end

  for (genvar k = 0; k < D; k++) begin : g_lane
    assign w_rise[k] = (w_cnt_adv == DIV_LOG2'(k));
    assign w_fall[k] = ~lp_phase_level(32'(w_cnt_adv), k, D);

    lp_phase_div_lane u_lane (
      .i_clk        (clk_i),
      .i_rst        (rst_i),
      .i_rule_state (w_rule_state),
      .i_rise       (w_rise[k]),
      .i_fall       (w_fall[k]),
      .o_mask_next  (w_mask_next[k]),
      .o_phase      (phase_o[k]),
      .o_prst       (prst_o[k])
    );
  end

  // Control register stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_frame  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_frame  <= (w_cnt_next == DIV_LOG2'(D - 1)) & w_all_run;
      r_locked <= w_all_run & (w_state_next == RUN);
    end
  end

  assign frame_o  = r_frame;
  assign locked_o = r_locked;

endmodule

// File: tb/tb_lp_phase_divider.sv
// ----------------------------------------------------------------------------
// tb_lp_phase_divider
// Five dividers (D = 2, 4, 4, 8, 32) share clock, reset, enable and resync.
// Each is compared every cycle against a behavioural model built from the
// per-phase rules (a phase joins at its rise, leaves at its fall), plus
// directed checks of the documented waveforms and pulse widths.
// ----------------------------------------------------------------------------
module tb_lp_phase_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, rs;
  logic [0:0]  st1;
  logic [1:0]  st2, st2b;
  logic [2:0]  st3;
  logic [4:0]  st5;
  logic [1:0]  p1, q1;
  logic [3:0]  p2, q2, p2b, q2b;
  logic [7:0]  p3, q3;
  logic [31:0] p5, q5;
  logic [4:0]  frm, lck;

  lp_phase_divider #(.DIV_LOG2(1)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .resync_i(rs), .start_phase_i(st1),
    .phase_o(p1), .prst_o(q1), .frame_o(frm[0]), .locked_o(lck[0]));
  lp_phase_divider #(.DIV_LOG2(2)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .resync_i(rs), .start_phase_i(st2),
    .phase_o(p2), .prst_o(q2), .frame_o(frm[1]), .locked_o(lck[1]));
  lp_phase_divider #(.DIV_LOG2(2)) u2b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .resync_i(rs), .start_phase_i(st2b),
    .phase_o(p2b), .prst_o(q2b), .frame_o(frm[2]), .locked_o(lck[2]));
  lp_phase_divider #(.DIV_LOG2(3)) u3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .resync_i(rs), .start_phase_i(st3),
    .phase_o(p3), .prst_o(q3), .frame_o(frm[3]), .locked_o(lck[3]));
  lp_phase_divider #(.DIV_LOG2(5)) u5 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .resync_i(rs), .start_phase_i(st5),
    .phase_o(p5), .prst_o(q5), .frame_o(frm[4]), .locked_o(lck[4]));

  // Behavioural model: which phases are active, whether the divider is busy
  // and whether it is winding down; the counter is a plain integer mod d.
  typedef struct {
    int        d;
    int        cnt;
    bit        busy;
    bit        winding;
    bit [31:0] act;
  } mdl_t;

  mdl_t  m[5];
  int    runlen[5][32];
  int    n_tests = 0;
  int    n_fail  = 0;
  string nm[5]   = '{"u1", "u2", "u2b", "u3", "u5"};
  int    dd[5]   = '{2, 4, 4, 8, 32};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit lvl(int d, int c, int k);
    return ((c - k + d) % d) < (d / 2);
  endfunction

  function automatic bit [31:0] full_mask(int d);
    bit [31:0] f = '0;
    for (int k = 0; k < d; k++) f[k] = 1'b1;
    return f;
  endfunction

  function automatic mdl_t m_init(int d);
    mdl_t s;
    s.d = d; s.cnt = 0; s.busy = 0; s.winding = 0; s.act = '0;
    return s;
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit r, bit e, bit sy, int st);
    mdl_t n;
    int   c;
    n = s;
    if (r) return m_init(s.d);
    if (!s.busy) begin
      n.cnt = st;
      if (e) begin
        n.busy      = 1'b1;
        n.act[st]   = 1'b1;
      end
    end else begin
      c     = (s.cnt + 1) % s.d;
      n.cnt = c;
      if (!s.winding && e && !sy) begin
        n.act[c] = 1'b1;
      end else begin
        n.winding = 1'b1;
        for (int k = 0; k < s.d; k++)
          if (!lvl(s.d, c, k)) n.act[k] = 1'b0;
        if (n.act == 32'd0) begin
          n.busy    = 1'b0;
          n.winding = 1'b0;
          n.cnt     = st;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] m_phase(mdl_t s);
    logic [31:0] p = '0;
    for (int k = 0; k < s.d; k++) p[k] = s.act[k] && lvl(s.d, s.cnt, k);
    return p;
  endfunction

  function automatic logic [31:0] m_prst(mdl_t s);
    logic [31:0] p = '0;
    for (int k = 0; k < s.d; k++) p[k] = !s.act[k];
    return p;
  endfunction

  function automatic logic m_locked(mdl_t s);
    return (s.act == full_mask(s.d)) && !s.winding;
  endfunction

  function automatic logic m_frame(mdl_t s);
    return (s.act == full_mask(s.d)) && (s.cnt == s.d - 1);
  endfunction

  // One clock edge: advance models with the inputs seen at the edge, then
  // compare every output and track high-pulse widths.
  task automatic tick();
    bit          r_s, e_s, s_s;
    int          sv[5];
    logic [31:0] op[5];
    logic [31:0] oq[5];
    r_s = rst; e_s = en; s_s = rs;
    sv[0] = int'(st1); sv[1] = int'(st2); sv[2] = int'(st2b);
    sv[3] = int'(st3); sv[4] = int'(st5);
    @(posedge clk);
    for (int i = 0; i < 5; i++) m[i] = mstep(m[i], r_s, e_s, s_s, sv[i]);
    #1;
    op[0] = 32'(p1);  oq[0] = 32'(q1);
    op[1] = 32'(p2);  oq[1] = 32'(q2);
    op[2] = 32'(p2b); oq[2] = 32'(q2b);
    op[3] = 32'(p3);  oq[3] = 32'(q3);
    op[4] = p5;       oq[4] = q5;
    for (int i = 0; i < 5; i++) begin
      chk({nm[i], "_phase"},  op[i], m_phase(m[i]));
      chk({nm[i], "_prst"},   oq[i], m_prst(m[i]));
      chk({nm[i], "_frame"},  32'(frm[i]), 32'(m_frame(m[i])));
      chk({nm[i], "_locked"}, 32'(lck[i]), 32'(m_locked(m[i])));
      for (int k = 0; k < m[i].d; k++) begin
        if (r_s) runlen[i][k] = 0;
        else if (op[i][k]) runlen[i][k]++;
        else if (runlen[i][k] > 0) begin
          chk($sformatf("%s_pw%0d", nm[i], k), 32'(runlen[i][k]), 32'(m[i].d / 2));
          runlen[i][k] = 0;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] prev;
    bit         found;

    rst = 1'b1; en = 1'b0; rs = 1'b0;
    st1 = '0; st2 = 2'd0; st2b = 2'd1; st3 = 3'd5; st5 = '0;
    for (int i = 0; i < 5; i++) begin
      m[i] = m_init(dd[i]);
      for (int k = 0; k < 32; k++) runlen[i][k] = 0;
    end

    // Reset state
    tick(); tick();
    chk("rst_phase", 32'(p2), 32'h0);
    chk("rst_prst",  32'(q2), 32'hf);
    chk("rst_lock",  32'(lck), 32'h0);
    chk("rst_frame", 32'(frm), 32'h0);
    rst = 1'b0;
    tick(); tick();

    // Startup, D=4, start 0 (u2); u2b starts at 1
    en = 1'b1;
    tick(); chk("up0_ph", 32'(p2), 32'b0001); chk("up0_pr", 32'(q2), 32'b1110);
    tick(); chk("up1_ph", 32'(p2), 32'b0011); chk("up1_pr", 32'(q2), 32'b1100);
    tick(); chk("up2_ph", 32'(p2), 32'b0110); chk("up2_pr", 32'(q2), 32'b1000);
    tick(); chk("up3_ph", 32'(p2), 32'b1100); chk("up3_pr", 32'(q2), 32'b0000);
    chk("up3_lock", 32'(lck[1]), 32'h1);
    chk("up3_frame", 32'(frm[1]), 32'h1);
    // u2 (start 0) trails u2b (start 1) by one fast cycle
    for (int j = 0; j < 4; j++) begin
      prev = p2b;
      tick();
      chk("chain", 32'(p2), 32'(prev));
      if (j == 1) chk("frame_gap", 32'(frm[1]), 32'h0);
      if (j == 3) chk("frame_e7", 32'(frm[1]), 32'h1);
    end
    tick();

    // Stop with cnt_next = 1
    en = 1'b0;
    tick(); chk("stop0_ph", 32'(p2), 32'b0011); chk("stop0_lock", 32'(lck[1]), 32'h0);
    chk("stop0_frame", 32'(frm[1]), 32'h0);
    tick(); chk("stop1_ph", 32'(p2), 32'b0010);
    tick(); chk("stop2_ph", 32'(p2), 32'b0000); chk("stop2_pr", 32'(q2), 32'hf);
    repeat (40) tick();

    // Resync with en held high, D=8 start 5
    en = 1'b1;
    repeat (40) tick();
    chk("rsy_pre_lock", 32'(lck[3]), 32'h1);
    rs = 1'b1; tick(); rs = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 12 && !found; j++) begin
      tick();
      if (q3 == 8'hff) found = 1'b1;
    end
    chk("rsy_drain_done", 32'(found), 32'h1);
    tick();
    chk("rsy_first_ph", 32'(p3), 32'h20);
    chk("rsy_first_pr", 32'(q3), 32'hdf);
    repeat (5) tick();
    tick(); chk("rsy_e6_lock", 32'(lck[3]), 32'h0);
    tick(); chk("rsy_e7_lock", 32'(lck[3]), 32'h1);

    // Resync together with en fall: single drain, no restart
    rs = 1'b1; en = 1'b0; tick(); rs = 1'b0;
    repeat (40) tick();
    chk("rsyfall_u3_pr", 32'(q3), 32'hff);
    chk("rsyfall_u5_pr", q5, 32'hffff_ffff);
    chk("rsyfall_lock", 32'(lck), 32'h0);

    // en pulse during DRAIN is ignored
    en = 1'b1;
    repeat (40) tick();
    en = 1'b0; tick();
    en = 1'b1; tick();
    en = 1'b0;
    repeat (3) tick();
    chk("drnpulse_lock", 32'(lck[4]), 32'h0);
    repeat (40) tick();
    chk("drnpulse_idle", q5, 32'hffff_ffff);

    // Reset during RUN
    en = 1'b1;
    repeat (10) tick();
    rst = 1'b1; tick();
    chk("midrst_ph2", 32'(p2), 32'h0);
    chk("midrst_pr2", 32'(q2), 32'hf);
    chk("midrst_ph5", p5, 32'h0);
    chk("midrst_pr5", q5, 32'hffff_ffff);
    chk("midrst_lock", 32'(lck), 32'h0);
    chk("midrst_frame", 32'(frm), 32'h0);
    rst = 1'b0;

    // Long run: D=2 complementary, D=32 pulse widths tracked in tick()
    for (int j = 0; j < 200; j++) begin
      tick();
      if (lck[0]) chk("u1_compl", 32'(p1[0] ^ p1[1]), 32'h1);
    end

    // Randomised operation
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(15) == 0) en = ~en;
      rs  = ($urandom_range(24) == 0);
      rst = ($urandom_range(399) == 0);
      if ($urandom_range(63) == 0) begin
        st1 = 1'($urandom); st2 = 2'($urandom); st2b = 2'($urandom);
        st3 = 3'($urandom); st5 = 5'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
